// File: rtl/alu_wb_stage.sv
// alu_wb_stage
//
// Execute-to-writeback stage sitting directly behind the 16-bit ALU.
// It captures each ALU result together with its destination metadata,
// holds up to two results in a head/skid buffer feeding the register-file
// write port, keeps the architectural status register {V,N,Z}, evaluates
// branch conditions from that status, and counts retired results.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready is a flop output)
//   in_out            ALU result
//   in_Z              ALU flags {V,N,Z}
//   in_aluop          ALU op that made the result: 00 add, 01 sub, 10 and, 11 not
//   in_rd, in_we      destination index and register-file write enable
//   in_setflags       result updates the status register
//   out_valid/out_ready downstream handshake toward the register file
//   out_data, out_rd, out_we  head entry contents
//   status            architectural flags {V,N,Z}
//   cond_sel          condition query, cond_true is its combinational answer
//   retired           number of entries handed downstream (wraps at 16 bits)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready never depends combinationally on the other side's valid.
// Here in_ready is registered (it is !skid_valid after each update) and
// out_* are driven from the head register only, so they hold while stalled.

module alu_wb_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_out,
  input  logic [2:0]    in_Z,
  input  logic [1:0]    in_aluop,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic          in_setflags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic [2:0]    status,
  input  logic [2:0]    cond_sel,
  output logic          cond_true,
  output logic [15:0]   retired
);

  // Condition codes for cond_sel
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_MI = 3'b101;
  localparam logic [2:0] COND_PL = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  // Head (H) register: the entry currently presented downstream
  logic          h_valid;
  logic [DW-1:0] h_data;
  logic [RW-1:0] h_rd;
  logic          h_we;

  // Skid (S) register: catches an accept while H is stalled
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [RW-1:0] s_rd;
  logic          s_we;

  logic          in_ready_q;
  logic [2:0]    status_q;
  logic [15:0]   retired_q;

  logic          accept;
  logic          handoff;
  logic [2:0]    flags_clean;

  // Next-state controls for the buffer
  logic          h_valid_n;
  logic          s_valid_n;
  logic          h_load_in;
  logic          h_load_s;
  logic          s_load;

  assign accept  = in_valid & in_ready_q;
  assign handoff = h_valid & out_ready;

  // The ALU leaves V undefined for logical ops (and/not), so it is cleared
  // before it can reach the status register. N and Z pass through.
  always_comb begin
    flags_clean = in_Z;
    if (in_aluop[1]) begin
      flags_clean[2] = 1'b0;
    end
  end

  // Buffer occupancy update. S is only ever valid while H is valid, and
  // while S is valid in_ready is low so no accept can arrive.
  always_comb begin
    h_valid_n = h_valid;
    s_valid_n = s_valid;
    h_load_in = 1'b0;
    h_load_s  = 1'b0;
    s_load    = 1'b0;
    case ({h_valid, s_valid})
      2'b10: begin
        if (handoff && accept) begin
          h_load_in = 1'b1;
        end else if (handoff) begin
          h_valid_n = 1'b0;
        end else if (accept) begin
          s_load    = 1'b1;
          s_valid_n = 1'b1;
        end
      end
      2'b11: begin
        if (handoff) begin
          h_load_s  = 1'b1;
          s_valid_n = 1'b0;
        end
      end
      default: begin
        // H empty: an accept goes straight to H
        if (accept) begin
          h_load_in = 1'b1;
          h_valid_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_valid    <= 1'b0;
      h_data     <= '0;
      h_rd       <= '0;
      h_we       <= 1'b0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_rd       <= '0;
      s_we       <= 1'b0;
      in_ready_q <= 1'b1;
      status_q   <= 3'b000;
      retired_q  <= 16'd0;
    end else begin
      h_valid    <= h_valid_n;
      s_valid    <= s_valid_n;
      in_ready_q <= ~s_valid_n;

      if (h_load_in) begin
        h_data <= in_out;
        h_rd   <= in_rd;
        h_we   <= in_we;
      end else if (h_load_s) begin
        h_data <= s_data;
        h_rd   <= s_rd;
        h_we   <= s_we;
      end

      if (s_load) begin
        s_data <= in_out;
        s_rd   <= in_rd;
        s_we   <= in_we;
      end

      // Status follows issue order: it updates at accept, not at handoff,
      // so downstream stalls never delay a flag change.
      if (accept && in_setflags) begin
        status_q <= flags_clean;
      end

      if (handoff) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  // Branch condition decode from the architectural status
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = status_q[0];
      COND_NE: cond_true = ~status_q[0];
      COND_LT: cond_true = status_q[1] ^ status_q[2];
      COND_GE: cond_true = ~(status_q[1] ^ status_q[2]);
      COND_MI: cond_true = status_q[1];
      COND_PL: cond_true = ~status_q[1];
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = h_valid;
  assign out_data  = h_data;
  assign out_rd    = h_rd;
  assign out_we    = h_we;
  assign status    = status_q;
  assign retired   = retired_q;

endmodule
